// File: rtl/onehot_encoder_pipe.sv
// onehot_encoder_pipe: two-stage pipelined priority encoder (highest set bit wins).
// Converts a WIDTH-bit vector to the binary index of its most significant set bit.
// It can also serve as a leading-one detector for posit regime/fraction normalisation.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   in_data is valid this cycle
//   in_ready   block accepts in_data this cycle (comb from out_ready only)
//   in_data    vector to encode
//   out_valid  out_index/out_zero(/out_multi) are valid
//   out_ready  consumer accepts the result this cycle
//   out_index  position of the highest set bit
//   out_zero   accepted vector was all zeros
//   out_multi  more than one bit set (only when ONEHOT_CHECK_EN is defined)
//
// Build option: define ONEHOT_CHECK_EN to add the out_multi port and its logic.

module onehot_encoder_pipe #(
    parameter int unsigned WIDTH = 16,
    localparam int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
`ifdef ONEHOT_CHECK_EN
    output logic             out_multi,
`endif
    output logic             out_zero
);

    // G nibbles; GW bits select a nibble (kept at least 1 bit wide for WIDTH=4)
    localparam int unsigned G  = WIDTH / 4;
    localparam int unsigned GW = (G > 1) ? $clog2(G) : 1;

    // Stage 1 state
    logic               s1_valid;
    logic [G-1:0]       s1_flag;
    logic [G-1:0][1:0]  s1_lidx;

    // Per-nibble combinational summary of in_data
    logic [G-1:0]       flag_c;
    logic [G-1:0][1:0]  lidx_c;

    // Stage 2 combinational selection from S1
    logic [GW-1:0]      sel_c;
    logic [1:0]         lsel_c;
    logic               any_c;
    logic [IDX_W-1:0]   index_c;

`ifdef ONEHOT_CHECK_EN
    logic [G-1:0]       s1_multi;
    logic [G-1:0]       multi_nib_c;
    logic               multi_c;
    logic               seen_c;
`endif

    // Handshake control
    logic s2_free_c;
    logic s1_load_c;
    logic s2_load_c;

    assign s2_free_c = !out_valid || out_ready;
    assign in_ready  = !s1_valid || s2_free_c;
    assign s1_load_c = in_valid && in_ready;
    assign s2_load_c = s1_valid && s2_free_c;

    // Per-nibble any-bit flag and local index of its highest set bit
    for (genvar g = 0; g < int'(G); g++) begin : g_nib
        logic [3:0] nib;
        assign nib       = in_data[4*g +: 4];
        assign flag_c[g] = |nib;
        assign lidx_c[g] = nib[3] ? 2'd3 :
                           nib[2] ? 2'd2 :
                           nib[1] ? 2'd1 : 2'd0;
`ifdef ONEHOT_CHECK_EN
        // Two or more bits set within this nibble
        assign multi_nib_c[g] = (nib[3] & (|nib[2:0])) |
                                (nib[2] & (|nib[1:0])) |
                                (nib[1] & nib[0]);
`endif
    end

    // Pick the highest flagged nibble; ascending scan lets the last hit win
    always_comb begin
        sel_c  = '0;
        lsel_c = 2'd0;
        any_c  = 1'b0;
        for (int unsigned g = 0; g < G; g++) begin
            if (s1_flag[g]) begin
                sel_c  = GW'(g);
                lsel_c = s1_lidx[g];
                any_c  = 1'b1;
            end
        end
        index_c = IDX_W'({sel_c, lsel_c});
    end

`ifdef ONEHOT_CHECK_EN
    // Multi-bit: any nibble holds several bits, or a second nibble is flagged
    always_comb begin
        multi_c = 1'b0;
        seen_c  = 1'b0;
        for (int unsigned g = 0; g < G; g++) begin
            multi_c = multi_c | s1_multi[g] | (s1_flag[g] & seen_c);
            seen_c  = seen_c | s1_flag[g];
        end
    end
`endif

    // Pipeline registers
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_flag   <= '0;
            s1_lidx   <= '0;
            out_valid <= 1'b0;
            out_index <= '0;
            out_zero  <= 1'b0;
`ifdef ONEHOT_CHECK_EN
            s1_multi  <= '0;
            out_multi <= 1'b0;
`endif
        end else begin
            if (s1_load_c) begin
                s1_flag  <= flag_c;
                s1_lidx  <= lidx_c;
`ifdef ONEHOT_CHECK_EN
                s1_multi <= multi_nib_c;
`endif
            end

            // S1 stays full when it is refilled in the same cycle it drains
            if (s1_load_c) begin
                s1_valid <= 1'b1;
            end else if (s2_load_c) begin
                s1_valid <= 1'b0;
            end

            if (s2_load_c) begin
                out_index <= index_c;
                out_zero  <= !any_c;
`ifdef ONEHOT_CHECK_EN
                out_multi <= multi_c;
`endif
            end

            if (s2_free_c) begin
                out_valid <= s1_valid;
            end
        end
    end

endmodule

// File: doc/onehot_encoder_pipe.md
Name: onehot_encoder_pipe

Overview:
- Inverse of the team's one-hot decoder: converts a WIDTH-bit vector back to a binary index.
- Priority rule: the highest set bit wins (MSB-first). The same unit therefore doubles as a leading-one detector for posit regime/fraction normalisation.
- Two-stage pipeline with valid/ready handshakes on input and output. Sits between the decode/normalise logic and downstream posit field extraction.

Parameters:
- WIDTH, 16, input vector width; must be a multiple of 4, range 4..64.
- IDX_W, $clog2(WIDTH), output index width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  WIDTH  vector to encode.
- out_valid  output  1  out_index/out_zero are valid.
- out_ready  input  1  consumer accepts the result this cycle.
- out_index  output  IDX_W  position of highest set bit of the accepted vector.
- out_zero  output  1  accepted vector was all zeros.
- out_multi  output  1  more than one bit set (present only with ONEHOT_CHECK_EN).

Behaviour:
- Reset: on clk edge with rst=1, all stage valids clear. out_valid=0, out_index=0, out_zero=0, out_multi=0. in_ready=1 from the first cycle after reset.
- rst has priority over any handshake in the same cycle. Data in flight at reset is discarded, never emitted.
- Transfer occurs on any edge where valid && ready on that interface.
- Stage 1 register (S1), loaded on an input transfer:
  - Split in_data into G=WIDTH/4 nibbles.
  - Per nibble: any-bit flag, plus 2-bit local index of its highest set bit (0 if nibble is zero).
- Stage 2 register (S2) drives the outputs:
  - Select the highest nibble g whose flag is set.
  - out_index = {g, local_idx[g]}.
  - If no flag is set: out_index=0, out_zero=1; otherwise out_zero=0.
- Flow control, with s2_free = !S2.valid || out_ready:
  - S2 loads from S1 when S1.valid && s2_free.
  - S1 loads from the input when in_ready && in_valid.
  - in_ready = !S1.valid || s2_free (combinational, no bubble).
- Latency: an input accepted at edge N appears on the outputs after edge N+1 (out_valid high in cycle N+1), provided out_ready stays high. Throughput: one result per cycle.
- Stall: out_valid=1 && out_ready=0 holds out_index/out_zero/out_multi stable. The block absorbs exactly one more input into S1, then deasserts in_ready.
- Simultaneous input accept and output release in the same cycle: both occur; no result is dropped or duplicated.
- Output ordering strictly follows input acceptance order.
- Outputs are don't-care while out_valid=0, but in practice hold their last value. The bench checks them only when out_valid=1.
- No combinational path from in_data to any output. The only comb path is out_ready -> in_ready.

Optional Feature:
- Macro: ONEHOT_CHECK_EN.
- Defined:
  - S1 also registers a per-nibble "two or more bits set" flag.
  - S2 sets out_multi=1 when any nibble has multiple bits or more than one nibble flag is set.
  - out_multi is registered and held like the other outputs.
  - out_index still reports the highest set bit.
- Undefined:
  - out_multi port and its logic are absent.
  - All other behaviour is identical.

Test Plan (WIDTH=16):
- Sweep: in_data=1<<k for k=0..15, back-to-back, out_ready=1 -> out_index=k, out_zero=0, one result per cycle, first result 2 cycles after the first accept.
- Priority and zero: in_data=16'h0000 -> out_zero=1, out_index=0. in_data=16'h0F01 -> out_index=11. in_data=16'h8001 -> out_index=15, with out_multi=1 when ONEHOT_CHECK_EN is defined.
- Backpressure: stream 8 inputs, hold out_ready=0 for 5 cycles after the first result -> in_ready falls after S1 fills. Outputs remain stable. Releasing gives all 8 results in order, none lost or duplicated.
- Random handshakes: random in_valid/out_ready for 1000 cycles, random data -> scoreboard matches a reference highest-set-bit model in order.
- Reset mid-stream: assert rst for 1 cycle with both stages full -> the next cycle has out_valid=0 and in_ready=1. Pre-reset data never appears on the outputs.
- Multi-bit check (ONEHOT_CHECK_EN defined): 16'h0010 -> out_multi=0. 16'h0030 -> out_multi=1, out_index=5. 16'h1010 -> out_multi=1, out_index=12.
